// File: rtl/wptr_full_lvl_pkg.sv
// Shared pointer helpers for the async FIFO write and read pointer controllers.
// Gray/binary conversions and depth derivation used on both clock sides.
package fifo_pkg;

    localparam int PTR_MAX_W = 32;

    function automatic int depth_of(input int addr_size);
        return 1 << addr_size;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(
        input logic [PTR_MAX_W-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    // Only the low w bits are meaningful; upper bits are zeroed.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(
        input logic [PTR_MAX_W-1:0] g,
        input int                   w
    );
        logic [PTR_MAX_W-1:0] b;
        logic                 acc;
        b   = '0;
        acc = 1'b0;
        for (int i = PTR_MAX_W - 1; i >= 0; i--) begin
            if (i < w) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_lvl_if.sv
// Write-side bundle between user logic / synchroniser and the write pointer
// controller; master drives requests, slave returns pointers and flags.
interface wptr_full_lvl_if #(
    parameter int ADDR_SIZE = 4
);

    logic                 winc;
    logic [ADDR_SIZE:0]   wq2_rptr;
    logic [ADDR_SIZE:0]   afull_lvl;
    logic                 wovf_clr;
    logic [ADDR_SIZE-1:0] waddr;
    logic [ADDR_SIZE:0]   wptr;
    logic                 wfull;
    logic                 wafull;
    logic [ADDR_SIZE:0]   wlevel;
    logic                 wovf;

    modport master (
        output winc,
        output wq2_rptr,
        output afull_lvl,
        output wovf_clr,
        input  waddr,
        input  wptr,
        input  wfull,
        input  wafull,
        input  wlevel,
        input  wovf
    );

    modport slave (
        input  winc,
        input  wq2_rptr,
        input  afull_lvl,
        input  wovf_clr,
        output waddr,
        output wptr,
        output wfull,
        output wafull,
        output wlevel,
        output wovf
    );

endinterface

// File: rtl/wptr_full_lvl_gray2bin.sv
// Combinational Gray to binary converter; bit i is the XOR of all Gray
// bits from the MSB down to i.
module gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/wptr_full_lvl.sv
// Write-domain pointer controller: binary/Gray write pointer, fill level,
// full / almost-full flags and a sticky overflow error.
module wptr_full_lvl
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE = 4
) (
    input  logic           wclk,
    input  logic           wrst,
    wptr_full_lvl_if.slave w
);

    localparam int W     = ADDR_SIZE + 1;
    localparam int DEPTH = depth_of(ADDR_SIZE);

    localparam logic [W-1:0] DEPTH_W = W'(DEPTH);

    logic [W-1:0] wbin;
    logic [W-1:0] wgray;
    logic [W-1:0] wlvl;
    logic         full_q;
    logic         afull_q;
    logic         ovf_q;

    logic         accept;
    logic [W-1:0] wbin_next;
    logic [W-1:0] wgray_next;
    logic [W-1:0] rbin;
    logic [W-1:0] lvl_next;

    gray2bin #(
        .W (W)
    ) u_rptr_g2b (
        .gray (w.wq2_rptr),
        .bin  (rbin)
    );

    assign accept     = w.winc & ~full_q;
    assign wbin_next  = wbin + W'(accept);
    assign wgray_next = W'(bin2gray(PTR_MAX_W'(wbin_next)));

    // Modular difference stays correct across pointer wrap.
    assign lvl_next   = wbin_next - rbin;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin    <= '0;
            wgray   <= '0;
            wlvl    <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
        end else begin
            wbin    <= wbin_next;
            wgray   <= wgray_next;
            wlvl    <= lvl_next;
            full_q  <= (lvl_next == DEPTH_W);
            afull_q <= (lvl_next >= w.afull_lvl);
        end
    end

    // A blocked write outranks a same-cycle clear so no overflow is lost.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            ovf_q <= 1'b0;
        end else if (w.winc & full_q) begin
            ovf_q <= 1'b1;
        end else if (w.wovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign w.waddr  = wbin[ADDR_SIZE-1:0];
    assign w.wptr   = wgray;
    assign w.wlevel = wlvl;
    assign w.wfull  = full_q;
    assign w.wafull = afull_q;
    assign w.wovf   = ovf_q;

endmodule

// File: tb/tb_wptr_full_lvl.sv
// Directed scoreboard bench for wptr_full_lvl with ADDR_SIZE = 4.
module tb_wptr_full_lvl;

    typedef struct {
        logic [4:0] wptr;
        logic [3:0] waddr;
        logic [4:0] lvl;
        logic       full;
        logic       afull;
        logic       ovf;
    } exp_t;

    logic wclk;
    logic wrst;

    wptr_full_lvl_if #(.ADDR_SIZE(4)) wif ();

    wptr_full_lvl #(
        .ADDR_SIZE (4)
    ) dut (
        .wclk (wclk),
        .wrst (wrst),
        .w    (wif)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    int   m_wbin = 0;
    bit   m_full = 0;
    bit   m_ovf  = 0;
    int   afl    = 12;
    exp_t q[$];

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit inc, input int rb, input bit clr,
                        input string tag);
        exp_t e;
        int   acc;
        int   nb;
        int   lvl;
        wif.winc     = inc;
        wif.wovf_clr = clr;
        wif.wq2_rptr = 5'(rb ^ (rb >> 1));
        acc     = (inc && !m_full) ? 1 : 0;
        nb      = (m_wbin + acc) & 31;
        lvl     = (nb - rb) & 31;
        e.wptr  = 5'(nb ^ (nb >> 1));
        e.waddr = 4'(nb & 15);
        e.lvl   = 5'(lvl);
        e.full  = (lvl == 16);
        e.afull = (lvl >= afl);
        e.ovf   = (inc && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        q.push_back(e);
        @(posedge wclk);
        #1;
        e = q.pop_front();
        chk({tag, ".wptr"},   32'(wif.wptr),   32'(e.wptr));
        chk({tag, ".waddr"},  32'(wif.waddr),  32'(e.waddr));
        chk({tag, ".wlevel"}, 32'(wif.wlevel), 32'(e.lvl));
        chk({tag, ".wfull"},  32'(wif.wfull),  32'(e.full));
        chk({tag, ".wafull"}, 32'(wif.wafull), 32'(e.afull));
        chk({tag, ".wovf"},   32'(wif.wovf),   32'(e.ovf));
        m_wbin = nb;
        m_full = e.full;
        m_ovf  = e.ovf;
        wif.winc     = 1'b0;
        wif.wovf_clr = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        wrst = 1'b1;
        #1;
        chk({tag, ".rst_wptr"},   32'(wif.wptr),   32'd0);
        chk({tag, ".rst_waddr"},  32'(wif.waddr),  32'd0);
        chk({tag, ".rst_wlevel"}, 32'(wif.wlevel), 32'd0);
        chk({tag, ".rst_wfull"},  32'(wif.wfull),  32'd0);
        chk({tag, ".rst_wafull"}, 32'(wif.wafull), 32'd0);
        chk({tag, ".rst_wovf"},   32'(wif.wovf),   32'd0);
        @(posedge wclk);
        #1;
        wif.wq2_rptr = '0;
        wrst   = 1'b0;
        m_wbin = 0;
        m_full = 0;
        m_ovf  = 0;
    endtask

    initial begin
        logic [4:0] prevg;
        int         rb;
        wrst          = 1'b1;
        wif.winc      = 1'b0;
        wif.wovf_clr  = 1'b0;
        wif.wq2_rptr  = '0;
        wif.afull_lvl = 5'd12;
        #3;
        do_reset("init");

        for (int i = 0; i < 7; i++) step(1, 0, 0, "pre");
        chk("pre.lvl7", 32'(wif.wlevel), 32'd7);
        do_reset("mid");
        step(0, 0, 0, "post_rst");

        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, "fill");
            if (i == 11) begin
                chk("fill12.wafull", 32'(wif.wafull), 32'd1);
                chk("fill12.wlevel", 32'(wif.wlevel), 32'd12);
            end
        end
        chk("full.wptr",  32'(wif.wptr),  32'b11000);
        chk("full.waddr", 32'(wif.waddr), 32'd0);
        chk("full.wfull", 32'(wif.wfull), 32'd1);

        step(1, 0, 0, "ovf");
        chk("ovf.wptr_held", 32'(wif.wptr), 32'b11000);
        chk("ovf.set",       32'(wif.wovf), 32'd1);
        step(1, 0, 1, "ovf_setwins");
        chk("ovf.setwins",   32'(wif.wovf), 32'd1);
        step(0, 0, 1, "ovf_clr");
        chk("ovf.clr",       32'(wif.wovf), 32'd0);

        step(0, 4, 0, "drain4");
        chk("drain4.wfull",  32'(wif.wfull),  32'd0);
        chk("drain4.wlevel", 32'(wif.wlevel), 32'd12);
        chk("drain4.wafull", 32'(wif.wafull), 32'd1);
        step(0, 5, 0, "drain5");
        chk("drain5.wafull", 32'(wif.wafull), 32'd0);
        chk("drain5.wlevel", 32'(wif.wlevel), 32'd11);

        step(0, (m_wbin - 3) & 31, 0, "trail");
        for (int i = 0; i < 40; i++) begin
            prevg = 5'(m_wbin ^ (m_wbin >> 1));
            rb    = (m_wbin + 1 - 3) & 31;
            step(1, rb, 0, "wrap");
            chk("wrap.lvl3",   32'(wif.wlevel), 32'd3);
            chk("wrap.onebit", 32'($countones(wif.wptr ^ prevg)), 32'd1);
        end

        afl = 0;
        wif.afull_lvl = 5'd0;
        do_reset("afl0");
        step(0, 0, 0, "afl0");
        chk("afl0.wafull", 32'(wif.wafull), 32'd1);

        afl = 17;
        wif.afull_lvl = 5'd17;
        do_reset("afl17");
        for (int i = 0; i < 16; i++) step(1, 0, 0, "afl17");
        chk("afl17.wfull",  32'(wif.wfull),  32'd1);
        chk("afl17.wafull", 32'(wif.wafull), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
